if_id_stage: RTL and testbench
==============================

# if_id_stage

Fetch-side responder to the pipeline hazard unit: owns the program counter and the IF/ID pipeline register, and applies the hazard unit's PCWrite, IF_ID_Write, IF_ID_Write_Flush and branchPCSrc controls on each clock edge. Sits between instruction memory and the decode stage. Adds a stage-status FSM and saturating stall/flush event counters for debug and CPI measurement.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on reset and on flush
- CNT_W, 16, width of StallCount and FlushCount
- Clk  input  1  single clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- PCWrite  input  1  1 = PC updates, 0 = PC holds
- IF_ID_Write  input  1  1 = IF/ID loads, 0 = IF/ID holds (stall)
- IF_ID_Write_Flush  input  1  active-low; 0 = IF/ID loads NOP_INSTR (flush)
- branchPCSrc  input  1  1 = next PC is BranchTarget
- BranchTarget  input  32  resolved branch/jump target
- Imem_Data  input  32  instruction word at address PC, combinational from PC
- PC  output  32  current fetch address, drives instruction memory
- IF_ID_Instruction  output  32  registered instruction to decode
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction
- IF_ID_Valid  output  1  1 = IF/ID holds a real fetched instruction
- StageState  output  2  FSM state encoding
- StallCount  output  CNT_W  stall cycles, saturating
- FlushCount  output  CNT_W  flush cycles, saturating

## Operation
- PC next-value priority: Reset -> RESET_PC; PCWrite=0 -> hold (even if branchPCSrc=1); branchPCSrc=1 -> BranchTarget; else PC+4. PC+4 wraps modulo 2^32; no alignment checking.
- IF/ID priority: Reset -> {NOP_INSTR, 0, Valid=0}; IF_ID_Write_Flush=0 -> {NOP_INSTR, 0, Valid=0} regardless of IF_ID_Write; IF_ID_Write=0 -> hold all three fields; else {Imem_Data, PC+4, Valid=1}.
- FSM states: FILL=2'd0, RUN=2'd1, STALL=2'd2, FLUSH=2'd3.
- Next state evaluated each edge with same priority as IF/ID: Reset -> FILL; flush -> FLUSH; IF_ID_Write=0 -> STALL; else RUN. FILL is left on the first non-reset edge.
- StallCount increments on every edge where IF_ID_Write=0 and IF_ID_Write_Flush=1 and Reset=0. FlushCount increments on every edge where IF_ID_Write_Flush=0 and Reset=0. Both stop at 2^CNT_W-1; both clear on Reset.
- Flush and stall in the same cycle: counts as flush only.

## Timing
- Reset values: PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0, StageState=FILL, StallCount=0, FlushCount=0.
- Fetch latency: instruction at PC appears on IF_ID_Instruction one edge later.
- All controls sampled on the same edge; no internal pipelining of controls. Stall of N cycles holds PC and IF/ID for exactly N edges.
- Branch: target appears on PC one edge after branchPCSrc=1 sampled; the wrong-path word fetched in that cycle is replaced by NOP in IF/ID on the same edge when the flush is asserted with it.
- Reset mid-stall or mid-flush: all state returns to reset values on that edge; counters clear.
- Outputs purely registered; no combinational path from inputs to outputs except PC -> Imem_Data externally.

## Structure
- Shared package: StageState encodings (FILL/RUN/STALL/FLUSH), NOP_INSTR default, PC increment constant 4.
- One natural sub-module: sat_counter (parameter width, inc, clear), instantiated twice for StallCount and FlushCount.
- PC register, IF/ID register and FSM live in the top module.

## Test plan
- Reset then 3 free-running edges with Imem_Data=mem[PC/4] -> PC 0,4,8,12; IF_ID_PCPlus4 4,8,12; Valid=1 from edge 1; StageState FILL then RUN.
- PC=0x20, PCWrite=0, IF_ID_Write=0 for 2 edges -> PC stays 0x20, IF/ID unchanged, StageState=STALL, StallCount=2.
- PC=0x40, branchPCSrc=1, BranchTarget=0x100, IF_ID_Write_Flush=0 -> next PC=0x100, IF_ID_Instruction=0, Valid=0, StageState=FLUSH, FlushCount=1.
- IF_ID_Write=0 and IF_ID_Write_Flush=0 same edge -> IF/ID flushed, FlushCount+1, StallCount unchanged.
- CNT_W=4, hold stall 20 edges -> StallCount saturates at 15.
- Reset asserted during stall with StallCount=5 -> PC=RESET_PC, Valid=0, StageState=FILL, StallCount=0 next edge.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared types and constants for the fetch stage.
// Stage status encodings, IF/ID bundle and PC step.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } stage_state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC      = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_stage_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge Clk) begin
    if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC, IF/ID register, status FSM
// and stall/flush counters driven by the hazard unit.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             IF_ID_Write,
  input  logic             IF_ID_Write_Flush,
  input  logic             branchPCSrc,
  input  logic [31:0]      BranchTarget,
  input  logic [31:0]      Imem_Data,
  output logic [31:0]      PC,
  output logic [31:0]      IF_ID_Instruction,
  output logic [31:0]      IF_ID_PCPlus4,
  output logic             IF_ID_Valid,
  output logic [1:0]       StageState,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [31:0]  pc_plus4;
  logic         flush;
  logic         stall;
  if_id_t       if_id;
  stage_state_t state;

  assign pc_plus4 = PC + PC_INC;
  assign flush    = !IF_ID_Write_Flush;
  assign stall    = IF_ID_Write_Flush && !IF_ID_Write;

  always_ff @(posedge Clk) begin
    if (Reset)
      PC <= RESET_PC;
    else if (PCWrite)
      PC <= branchPCSrc ? BranchTarget : pc_plus4;
  end

  // Flush beats stall so a wrong-path word never survives.
  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      if_id <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (IF_ID_Write) begin
      if_id <= '{instr: Imem_Data, pc_plus4: pc_plus4, valid: 1'b1};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= FILL;
    else if (flush)
      state <= FLUSH;
    else if (stall)
      state <= STALL;
    else
      state <= RUN;
  end

  assign IF_ID_Instruction = if_id.instr;
  assign IF_ID_PCPlus4     = if_id.pc_plus4;
  assign IF_ID_Valid       = if_id.valid;
  assign StageState        = state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .clear (Reset),
    .inc   (stall),
    .count (StallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .clear (Reset),
    .inc   (flush),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: vector table
// plus saturation, wrap and reset-mid-stall sequences.
module tb_if_id_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Write_Flush;
  logic        branchPCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] Imem_Data;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [1:0]  StageState;
  logic [3:0]  StallCount;
  logic [3:0]  FlushCount;

  int compared   = 0;
  int mismatched = 0;

  if_id_stage #(
    .RESET_PC  (32'h0),
    .NOP_INSTR (32'h0),
    .CNT_W     (4)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .PCWrite           (PCWrite),
    .IF_ID_Write       (IF_ID_Write),
    .IF_ID_Write_Flush (IF_ID_Write_Flush),
    .branchPCSrc       (branchPCSrc),
    .BranchTarget      (BranchTarget),
    .Imem_Data         (Imem_Data),
    .PC                (PC),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .StageState        (StageState),
    .StallCount        (StallCount),
    .FlushCount        (FlushCount)
  );

  always #5 Clk = ~Clk;

  // Memory image: each word tags its own address.
  assign Imem_Data = 32'hA000_0000 | PC;

  typedef struct {
    logic        rst, pcw, ifw, fln, br;
    logic [31:0] tgt;
    logic [31:0] pc, ins, p4;
    logic        v;
    logic [1:0]  st;
    logic [3:0]  sc, fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rst, logic pcw, logic ifw, logic fln,
    logic br, logic [31:0] tgt,
    logic [31:0] pc, logic [31:0] ins,
    logic [31:0] p4, logic v, logic [1:0] st,
    logic [3:0] sc, logic [3:0] fc);
    vec_t r;
    r.rst = rst; r.pcw = pcw; r.ifw = ifw;
    r.fln = fln; r.br = br; r.tgt = tgt;
    r.pc = pc; r.ins = ins; r.p4 = p4;
    r.v = v; r.st = st; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic pcw, logic ifw,
                       logic fln, logic br,
                       logic [31:0] tgt);
    @(negedge Clk);
    Reset = rst; PCWrite = pcw; IF_ID_Write = ifw;
    IF_ID_Write_Flush = fln; branchPCSrc = br;
    BranchTarget = tgt;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(string tag, vec_t e);
    chk({tag, ".pc"},    PC,                e.pc);
    chk({tag, ".instr"}, IF_ID_Instruction, e.ins);
    chk({tag, ".pc4"},   IF_ID_PCPlus4,     e.p4);
    chk({tag, ".valid"}, 32'(IF_ID_Valid),  32'(e.v));
    chk({tag, ".state"}, 32'(StageState),   32'(e.st));
    chk({tag, ".stall"}, 32'(StallCount),   32'(e.sc));
    chk({tag, ".flush"}, 32'(FlushCount),   32'(e.fc));
  endtask

  initial begin
    Reset = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1;
    IF_ID_Write_Flush = 1'b1; branchPCSrc = 1'b0;
    BranchTarget = '0;

    // rst pcw ifw fln br tgt | pc ins p4 v st sc fc
    vecs.push_back(mk(1,1,1,1,0,0,
      32'h0, 32'h0, 32'h0, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0,1,1,1,0,0,
      32'h4, 32'hA000_0000, 32'h4, 1, 2'd1, 0, 0));
    vecs.push_back(mk(0,1,1,1,0,0,
      32'h8, 32'hA000_0004, 32'h8, 1, 2'd1, 0, 0));
    vecs.push_back(mk(0,1,1,1,0,0,
      32'hC, 32'hA000_0008, 32'hC, 1, 2'd1, 0, 0));
    vecs.push_back(mk(0,1,1,1,1,32'h20,
      32'h20, 32'hA000_000C, 32'h10, 1, 2'd1, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,0,
      32'h20, 32'hA000_000C, 32'h10, 1, 2'd2, 1, 0));
    vecs.push_back(mk(0,0,0,1,0,0,
      32'h20, 32'hA000_000C, 32'h10, 1, 2'd2, 2, 0));
    vecs.push_back(mk(0,1,1,1,0,0,
      32'h24, 32'hA000_0020, 32'h24, 1, 2'd1, 2, 0));
    vecs.push_back(mk(0,1,1,1,1,32'h40,
      32'h40, 32'hA000_0024, 32'h28, 1, 2'd1, 2, 0));
    vecs.push_back(mk(0,1,1,0,1,32'h100,
      32'h100, 32'h0, 32'h0, 0, 2'd3, 2, 1));
    vecs.push_back(mk(0,1,1,1,0,0,
      32'h104, 32'hA000_0100, 32'h104, 1, 2'd1, 2, 1));
    vecs.push_back(mk(0,1,0,0,0,0,
      32'h108, 32'h0, 32'h0, 0, 2'd3, 2, 2));
    vecs.push_back(mk(0,0,1,1,1,32'h500,
      32'h108, 32'hA000_0108, 32'h10C, 1, 2'd1, 2, 2));
    vecs.push_back(mk(0,0,1,0,0,0,
      32'h108, 32'h0, 32'h0, 0, 2'd3, 2, 3));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pcw, vecs[i].ifw,
            vecs[i].fln, vecs[i].br, vecs[i].tgt);
      chk_all($sformatf("v%0d", i), vecs[i]);
    end

    // Stall saturation: from 2, twenty more stalls
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      if (i == 12) chk("sat.at15", 32'(StallCount), 32'd15);
    end
    chk("sat.final", 32'(StallCount), 32'd15);
    chk("sat.pc",    PC,              32'h108);
    chk("sat.flush", 32'(FlushCount), 32'd3);

    // Reset mid-stall with StallCount=5
    drive(1, 1, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      drive(0, 0, 0, 1, 0, 0);
    chk("rs.pre", 32'(StallCount), 32'd5);
    drive(1, 0, 0, 1, 0, 0);
    chk_all("rs", mk(1,0,0,1,0,0,
      32'h0, 32'h0, 32'h0, 0, 2'd0, 0, 0));

    // Reset mid-flush
    drive(0, 1, 1, 0, 0, 0);
    chk("rf.pre", 32'(FlushCount), 32'd1);
    drive(1, 1, 1, 0, 0, 0);
    chk("rf.flush", 32'(FlushCount), 32'd0);
    chk("rf.state", 32'(StageState), 32'd0);

    // PC+4 wraps modulo 2^32
    drive(0, 1, 1, 1, 1, 32'hFFFF_FFFC);
    chk("wrap.tgt", PC, 32'hFFFF_FFFC);
    drive(0, 1, 1, 1, 0, 0);
    chk("wrap.pc",  PC,                32'h0);
    chk("wrap.pc4", IF_ID_PCPlus4,     32'h0);
    chk("wrap.ins", IF_ID_Instruction, 32'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
